// File: rtl/btb_upd_sched.sv
// Round-robin scheduler of branch-resolution updates into the single BTB write port, with an
// update FIFO and a flush sequencer. Accept->write latency 2 cycles; ready is low when FIFO full or flushing.
module btb_upd_sched #(
    parameter int XLEN       = 32,
    parameter int N_REQ      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [N_REQ-1:0]                  req_valid_i,
    output logic [N_REQ-1:0]                  req_ready_o,
    input  logic [N_REQ-1:0]                  req_del_i,
    input  logic [N_REQ*XLEN-1:0]             req_pc_i,
    input  logic [N_REQ*XLEN-1:0]             req_target_i,
    input  logic                              flush_req_i,
    output logic                              btb_valid_o,
    output logic                              btb_del_o,
    output logic [XLEN-1:0]                   btb_pc_o,
    output logic [XLEN-1:0]                   btb_target_o,
    output logic                              btb_flush_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic            del;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } upd_t;

    state_t          state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [AW:0]     wr_q, rd_q, wr_nxt, rd_nxt;
    upd_t            mem [FIFO_DEPTH];
    upd_t            head, new_upd;

    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    win;
    logic             found, full, empty, accept_en, push, pop;
    int               idx;

    // First asserting requester at or after the round-robin pointer wins.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid_i[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = PW'(idx);
            end
        end
    end

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // Reset gates ready so no handshake can complete while the block is held in reset.
    assign accept_en = rst_n_i && !full && (state_q == RUN) && !flush_req_i;
    assign push      = found && accept_en;
    assign pop       = !empty && (state_q == RUN) && !flush_req_i;

    assign req_ready_o = grant & {N_REQ{accept_en}};

    assign new_upd.del    = req_del_i[win];
    assign new_upd.pc     = req_pc_i[int'(win)*XLEN +: XLEN];
    assign new_upd.target = req_target_i[int'(win)*XLEN +: XLEN];
    assign head           = mem[rd_q[AW-1:0]];

    always_comb begin
        wr_nxt = wr_q + {{AW{1'b0}}, push};
        rd_nxt = rd_q + {{AW{1'b0}}, pop};
        if (flush_req_i) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_q[AW-1:0]] <= new_upd;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= RUN;
            rr_ptr_q     <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            occupancy_o  <= '0;
            btb_valid_o  <= 1'b0;
            btb_del_o    <= 1'b0;
            btb_pc_o     <= '0;
            btb_target_o <= '0;
            btb_flush_o  <= 1'b0;
        end else begin
            wr_q        <= wr_nxt;
            rd_q        <= rd_nxt;
            occupancy_o <= OW'(wr_nxt - rd_nxt);
            btb_valid_o <= pop;
            if (pop) begin
                btb_del_o    <= head.del;
                btb_pc_o     <= head.pc;
                btb_target_o <= head.target;
            end
            if (push) rr_ptr_q <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
            // A held flush request re-enters FLUSH and emits one pulse per cycle.
            case (state_q)
                RUN: begin
                    btb_flush_o <= flush_req_i;
                    if (flush_req_i) state_q <= FLUSH;
                end
                FLUSH: begin
                    btb_flush_o <= flush_req_i;
                    if (!flush_req_i) state_q <= RUN;
                end
                default: begin
                    btb_flush_o <= 1'b0;
                    state_q     <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btb_upd_sched.sv
// Bench for btb_upd_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_btb_upd_sched;
    localparam int XLEN = 32, N_REQ = 2, DEPTH = 4, OW = $clog2(DEPTH + 1);

    logic             clk_i = 1'b0, rst_n_i = 1'b0;
    logic [1:0]       req_valid_i = '0, req_del_i = '0, req_ready_o;
    logic [63:0]      req_pc_i = '0, req_target_i = '0;
    logic             flush_req_i = 1'b0;
    logic             btb_valid_o, btb_del_o, btb_flush_o;
    logic [31:0]      btb_pc_o, btb_target_o;
    logic [OW-1:0]    occupancy_o;

    btb_upd_sched #(.XLEN(XLEN), .N_REQ(N_REQ), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_del_i(req_del_i),
        .req_pc_i(req_pc_i), .req_target_i(req_target_i), .flush_req_i(flush_req_i),
        .btb_valid_o(btb_valid_o), .btb_del_o(btb_del_o), .btb_pc_o(btb_pc_o),
        .btb_target_o(btb_target_o), .btb_flush_o(btb_flush_o), .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        del;
        logic [31:0] pc;
        logic [31:0] tgt;
    } upd_t;

    // Reference model: pending updates as a queue, arbitration by modular search.
    upd_t m_q[$];
    int   m_ptr = 0;
    bit   m_fl_state = 0, m_vld = 0, m_flush = 0;
    upd_t m_out = '0;
    int   m_last_acc = -1;
    int   n_chk = 0, n_pass = 0;

    function automatic logic [1:0] mdl_ready();
        logic [1:0] r;
        r = '0;
        if (!rst_n_i || m_fl_state || flush_req_i || m_q.size() >= DEPTH) return r;
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (req_valid_i[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [69:0] exp_bus();
        return {m_vld, m_out.del, m_out.pc, m_out.tgt, m_flush, OW'(m_q.size())};
    endfunction

    function automatic logic [69:0] dut_bus();
        return {btb_valid_o, btb_del_o, btb_pc_o, btb_target_o, btb_flush_o, occupancy_o};
    endfunction

    task automatic mdl_reset();
        m_q.delete();
        m_ptr = 0; m_fl_state = 0; m_vld = 0; m_flush = 0; m_out = '0; m_last_acc = -1;
    endtask

    // Advance the model across one clock edge using the inputs presented before it.
    task automatic mdl_edge();
        logic [1:0] r;
        bit   fl, can_pop;
        upd_t acc;
        r = mdl_ready();
        fl = flush_req_i;
        can_pop = (m_q.size() > 0) && !m_fl_state && !fl;
        acc = '0;
        m_last_acc = -1;
        for (int i = 0; i < N_REQ; i++)
            if (r[i]) begin
                m_last_acc = i;
                acc = '{del: req_del_i[i], pc: req_pc_i[i*32 +: 32], tgt: req_target_i[i*32 +: 32]};
            end
        @(posedge clk_i);
        m_vld = can_pop;
        if (can_pop) m_out = m_q.pop_front();
        if (m_last_acc >= 0) begin
            m_q.push_back(acc);
            m_ptr = (m_last_acc + 1) % N_REQ;
        end
        if (fl) m_q.delete();
        m_flush = fl;
        m_fl_state = fl;
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic d, input logic [31:0] pc, input logic [31:0] tgt);
        req_valid_i[i] = v;
        req_del_i[i] = d;
        req_pc_i[i*32 +: 32] = pc;
        req_target_i[i*32 +: 32] = tgt;
    endtask

    // Requesters hold until accepted, then optionally present a fresh random update.
    task automatic drive_random(input int pct_valid, input int pct_flush);
        for (int i = 0; i < N_REQ; i++)
            if (!req_valid_i[i] || m_last_acc == i)
                set_req(i, $urandom_range(99) < pct_valid, 1'($urandom_range(1)), $urandom, $urandom);
        flush_req_i = $urandom_range(99) < pct_flush;
    endtask

    task automatic idle(input int n);
        req_valid_i = '0;
        flush_req_i = 1'b0;
        for (int k = 0; k < n; k++) mdl_edge();
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (dut_bus() !== 70'h0) $display("FAIL reset_outputs got=%h exp=0", dut_bus());
        else n_pass++;
        req_valid_i = 2'b11;
        #1;
        n_chk++;
        if (req_ready_o !== 2'b00) $display("FAIL reset_ready got=%b exp=00", req_ready_o);
        else n_pass++;
        req_valid_i = 2'b00;
        rst_n_i = 1'b1;
        mdl_reset();
        mdl_edge();
        n_chk++;
        if (dut_bus() !== exp_bus()) $display("FAIL reset_after_release got=%h exp=%h", dut_bus(), exp_bus());
        else n_pass++;
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 1'b0, 32'h100, 32'h200);
        #1;
        n_chk++;
        if (req_ready_o !== 2'b01) $display("FAIL single_ready got=%b exp=01", req_ready_o);
        else n_pass++;
        mdl_edge();
        req_valid_i = '0;
        n_chk++;
        if ({btb_valid_o, occupancy_o} !== {1'b0, OW'(1)}) $display("FAIL single_queued got=%b/%0d exp=0/1", btb_valid_o, occupancy_o);
        else n_pass++;
        mdl_edge();
        n_chk++;
        if ({btb_valid_o, btb_del_o, btb_pc_o, btb_target_o, occupancy_o} !== {1'b1, 1'b0, 32'h100, 32'h200, OW'(0)})
            $display("FAIL single_write got v=%b pc=%h tgt=%h occ=%0d exp v=1 pc=100 tgt=200 occ=0", btb_valid_o, btb_pc_o, btb_target_o, occupancy_o);
        else n_pass++;
        mdl_edge();
        n_chk++;
        if ({btb_valid_o, btb_pc_o} !== {1'b0, 32'h100}) $display("FAIL single_hold got v=%b pc=%h exp v=0 pc=100", btb_valid_o, btb_pc_o);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int cnt[2];
        int prev;
        bit alt_ok;
        cnt[0] = 0; cnt[1] = 0; prev = -1; alt_ok = 1;
        set_req(0, 1'b1, 1'b0, 32'hA000, $urandom);
        set_req(1, 1'b1, 1'b0, 32'hB000, $urandom);
        for (int c = 0; c < 16; c++) begin
            #1;
            n_chk++;
            if (req_ready_o !== mdl_ready()) $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, req_ready_o, mdl_ready());
            else n_pass++;
            mdl_edge();
            if (m_last_acc >= 0) begin
                cnt[m_last_acc]++;
                if (m_last_acc == prev) alt_ok = 0;
                prev = m_last_acc;
                set_req(m_last_acc, 1'b1, 1'b0, (m_last_acc == 0 ? 32'hA000 : 32'hB000) + 32'(c), $urandom);
            end
            n_chk++;
            if (dut_bus() !== exp_bus()) $display("FAIL rr_out cyc=%0d got=%h exp=%h", c, dut_bus(), exp_bus());
            else n_pass++;
        end
        n_chk++;
        if (!(alt_ok && cnt[0] == 8 && cnt[1] == 8)) $display("FAIL rr_fairness got g0=%0d g1=%0d alt=%0d exp 8/8 alternating", cnt[0], cnt[1], alt_ok);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] sent[$];
        logic [31:0] seen[$];
        int k;
        k = 0;
        set_req(0, 1'b1, 1'b0, 32'h1000, 32'h9000);
        for (int c = 0; c < 30 && (k < 6 || c < 12); c++) begin
            #1;
            if (k < 6) begin
                n_chk++;
                if (req_ready_o !== mdl_ready()) $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, req_ready_o, mdl_ready());
                else n_pass++;
            end
            mdl_edge();
            if (m_last_acc == 0) begin
                sent.push_back(32'h1000 + 32'(k * 16));
                k++;
                if (k < 6) set_req(0, 1'b1, 1'b0, 32'h1000 + 32'(k * 16), 32'h9000 + 32'(k));
                else req_valid_i = '0;
            end
            if (btb_valid_o) seen.push_back(btb_pc_o);
        end
        n_chk++;
        if (seen.size() != 6 || sent.size() != 6) $display("FAIL b2b_count got=%0d exp=6", seen.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < seen.size(); i++) begin
            n_chk++;
            if (seen[i] !== 32'h1000 + 32'(i * 16)) $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, seen[i], 32'h1000 + 32'(i * 16));
            else n_pass++;
        end
    endtask

    task automatic test_delete();
        bit hit;
        hit = 0;
        set_req(1, 1'b1, 1'b1, 32'h340, 32'hDEAD);
        for (int c = 0; c < 8 && !hit; c++) begin
            mdl_edge();
            if (m_last_acc == 1) req_valid_i = '0;
            if (btb_valid_o) begin
                hit = 1;
                n_chk++;
                if ({btb_del_o, btb_pc_o} !== {1'b1, 32'h340}) $display("FAIL delete got del=%b pc=%h exp del=1 pc=340", btb_del_o, btb_pc_o);
                else n_pass++;
            end
        end
        if (!hit) begin
            n_chk++;
            $display("FAIL delete_timeout got no btb_valid_o exp write within 8 cycles");
        end
    endtask

    task automatic test_flush(input int len);
        set_req(0, 1'b1, 1'b0, 32'h5000, 32'h1);
        set_req(1, 1'b1, 1'b0, 32'h6000, 32'h2);
        mdl_edge();
        mdl_edge();
        flush_req_i = 1'b1;
        for (int c = 0; c < len + 3; c++) begin
            if (c == len) flush_req_i = 1'b0;
            #1;
            n_chk++;
            if (req_ready_o !== mdl_ready() || (c <= len && req_ready_o !== 2'b00))
                $display("FAIL flush_ready len=%0d cyc=%0d got=%b exp=%b", len, c, req_ready_o, mdl_ready());
            else n_pass++;
            mdl_edge();
            if (m_last_acc >= 0) req_valid_i[m_last_acc] = 1'b0;
            n_chk++;
            if (dut_bus() !== exp_bus() || btb_flush_o !== (c < len) || (c >= 1 && c <= len + 1 && btb_valid_o))
                $display("FAIL flush_out len=%0d cyc=%0d got=%h exp=%h", len, c, dut_bus(), exp_bus());
            else n_pass++;
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 1'b0, 32'h7000, 32'h7);
        mdl_edge();
        set_req(0, 1'b1, 1'b0, 32'h7010, 32'h8);
        mdl_edge();
        #2;
        rst_n_i = 1'b0;
        #1;
        n_chk++;
        if (dut_bus() !== 70'h0 || req_ready_o !== 2'b00) $display("FAIL midreset_outputs got=%h rdy=%b exp=0", dut_bus(), req_ready_o);
        else n_pass++;
        req_valid_i = '0;
        #2;
        rst_n_i = 1'b1;
        mdl_reset();
        for (int c = 0; c < 3; c++) begin
            mdl_edge();
            n_chk++;
            if (btb_valid_o !== 1'b0 || btb_flush_o !== 1'b0) $display("FAIL midreset_quiet cyc=%0d got v=%b f=%b exp 0/0", c, btb_valid_o, btb_flush_o);
            else n_pass++;
        end
        req_valid_i = 2'b11;
        #1;
        n_chk++;
        if (req_ready_o !== 2'b01) $display("FAIL midreset_ptr got=%b exp=01", req_ready_o);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive_random(60, 4);
            #1;
            n_chk++;
            if (req_ready_o !== mdl_ready()) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready_o, mdl_ready());
            else n_pass++;
            mdl_edge();
            n_chk++;
            if (dut_bus() !== exp_bus()) $display("FAIL rand_out cyc=%0d got=%h exp=%h", c, dut_bus(), exp_bus());
            else n_pass++;
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_delete();
        test_flush(1);
        test_flush(2);
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
